// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU operation sequencer: opcodes, FSM states and the
// 22-bit ALU control bundle.
package alu_seq_pkg;

   localparam int SETTLE_MAX = 15;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_ADC  = 4'd1,
      OP_SUB  = 4'd2,
      OP_SBC  = 4'd3,
      OP_NEG  = 4'd4,
      OP_AND  = 4'd5,
      OP_OR   = 4'd6,
      OP_XOR  = 4'd7,
      OP_NOT  = 4'd8,
      OP_NAND = 4'd9,
      OP_NOR  = 4'd10,
      OP_LSL  = 4'd11,
      OP_LSR  = 4'd12,
      OP_ASR  = 4'd13,
      OP_LUI  = 4'd14,
      OP_LLI  = 4'd15
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } seq_state_e;

   typedef struct packed {
      logic cin;
      logic sub;
      logic zero_a;
      logic fa_out;
      logic and_op;
      logic or_op;
      logic xor_op;
      logic not_op;
      logic nand_op;
      logic nor_op;
      logic sign;
      logic sh_sign_in;
      logic sh1;
      logic sh2;
      logic sh4;
      logic sh8;
      logic sh_b;
      logic sh_l;
      logic sh_r;
      logic sh_out;
      logic lli;
      logic alu_enable;
   } alu_ctrl_t;

   // Only adder-path ops are allowed to update the carry and overflow flags.
   function automatic logic op_sets_carry(alu_op_e op);
      return (op == OP_ADD) || (op == OP_ADC) || (op == OP_SUB) ||
             (op == OP_SBC) || (op == OP_NEG);
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: opcode, shift controls and carry-in flag
// to the one-hot ALU_16Slice control bundle.
module alu_op_decode
   import alu_seq_pkg::*;
(
   input  alu_op_e    i_op,
   input  logic [3:0] i_sh_amt,
   input  logic       i_sh_src_b,
   input  logic       i_flag_c,
   output alu_ctrl_t  o_ctrl
);

   always_comb begin
      o_ctrl            = '0;
      o_ctrl.alu_enable = 1'b1;
      case (i_op)
         OP_ADD: o_ctrl.fa_out = 1'b1;
         OP_ADC: begin
            o_ctrl.fa_out = 1'b1;
            o_ctrl.cin    = i_flag_c;
         end
         OP_SUB: begin
            o_ctrl.fa_out = 1'b1;
            o_ctrl.sub    = 1'b1;
            o_ctrl.cin    = 1'b1;
         end
         OP_SBC: begin
            o_ctrl.fa_out = 1'b1;
            o_ctrl.sub    = 1'b1;
            o_ctrl.cin    = i_flag_c;
         end
         OP_NEG: begin
            o_ctrl.fa_out = 1'b1;
            o_ctrl.sub    = 1'b1;
            o_ctrl.zero_a = 1'b1;
            o_ctrl.cin    = 1'b1;
         end
         OP_AND:  o_ctrl.and_op  = 1'b1;
         OP_OR:   o_ctrl.or_op   = 1'b1;
         OP_XOR:  o_ctrl.xor_op  = 1'b1;
         OP_NOT:  o_ctrl.not_op  = 1'b1;
         OP_NAND: o_ctrl.nand_op = 1'b1;
         OP_NOR:  o_ctrl.nor_op  = 1'b1;
         OP_LSL, OP_LSR, OP_ASR: begin
            o_ctrl.sh_out     = 1'b1;
            o_ctrl.sh_l       = (i_op == OP_LSL);
            o_ctrl.sh_r       = (i_op != OP_LSL);
            o_ctrl.sh_sign_in = (i_op == OP_ASR);
            {o_ctrl.sh8, o_ctrl.sh4, o_ctrl.sh2, o_ctrl.sh1} = i_sh_amt;
            o_ctrl.sh_b       = i_sh_src_b;
         end
         OP_LUI: begin
            o_ctrl.sh_out = 1'b1;
            o_ctrl.sh_l   = 1'b1;
            o_ctrl.sh_b   = 1'b1;
            o_ctrl.sh8    = 1'b1;
         end
         OP_LLI: begin
            o_ctrl.sh_out = 1'b1;
            o_ctrl.lli    = 1'b1;
         end
         default: o_ctrl = '0;
      endcase
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue-side driver for ALU_16Slice: accept, hold controls for a settle window,
// capture result and flags. Define ALU_BACK2BACK_EN to accept in DONE.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int WIDTH         = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             OpValid,
   output logic             OpReady,
   input  logic [3:0]       OpCode,
   input  logic [WIDTH-1:0] OpA,
   input  logic [WIDTH-1:0] OpB,
   input  logic [3:0]       ShAmt,
   input  logic             ShSrcB,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic             CIn,
   output logic             SUB,
   output logic             ZeroA,
   output logic             FAOut,
   output logic             AND,
   output logic             OR,
   output logic             XOR,
   output logic             NOT,
   output logic             NAND,
   output logic             NOR,
   output logic             Sign,
   output logic             ShSignIn,
   output logic             Sh1,
   output logic             Sh2,
   output logic             Sh4,
   output logic             Sh8,
   output logic             ShB,
   output logic             ShL,
   output logic             ShR,
   output logic             ShOut,
   output logic             LLI,
   output logic             ALUEnable,
   input  logic [WIDTH-1:0] ALUOut,
   input  logic             COut,
   input  logic             CIn_Slice,
   input  logic             nZ,
   input  logic             Sum,
   output logic             ResValid,
   input  logic             ResReady,
   output logic [WIDTH-1:0] Result,
   output logic             FlagZ,
   output logic             FlagN,
   output logic             FlagC,
   output logic             FlagV,
   output seq_state_e       o_dbg_state
);

   localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

   // Handshakes: a transfer happens on a rising edge where valid and ready
   // are both 1; valid must be held until then, ready may change freely.
   seq_state_e       r_state;
   logic             r_op_ready;
   logic [3:0]       r_cnt;
   logic [WIDTH-1:0] r_a, r_b, r_result;
   alu_ctrl_t        r_ctrl;
   logic             r_arith;
   logic             r_res_valid;
   logic             r_flag_z, r_flag_n, r_flag_c, r_flag_v;
   alu_ctrl_t        w_ctrl;
   logic             w_load;

   // Capture happens on the EXEC->DONE edge, so r_flag_c already holds the
   // previous op's carry even when the next op is accepted straight from DONE.
   alu_op_decode u_decode (
      .i_op       (alu_op_e'(OpCode)),
      .i_sh_amt   (ShAmt),
      .i_sh_src_b (ShSrcB),
      .i_flag_c   (r_flag_c),
      .o_ctrl     (w_ctrl)
   );

   always_comb begin
      w_load  = (r_state == ST_IDLE) && OpValid && r_op_ready;
      OpReady = r_op_ready;
`ifdef ALU_BACK2BACK_EN
      w_load  = w_load || ((r_state == ST_DONE) && OpValid && ResReady);
      OpReady = r_op_ready || ((r_state == ST_DONE) && ResReady);
`endif
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state     <= ST_IDLE;
         r_op_ready  <= 1'b0;
         r_cnt       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_ctrl      <= '0;
         r_arith     <= 1'b0;
         r_result    <= '0;
         r_res_valid <= 1'b0;
         r_flag_z    <= 1'b0;
         r_flag_n    <= 1'b0;
         r_flag_c    <= 1'b0;
         r_flag_v    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: r_op_ready <= 1'b1;
            ST_EXEC: begin
               if (r_cnt == 4'd0) begin
                  r_result    <= ALUOut;
                  r_flag_z    <= ~nZ;
                  r_flag_n    <= Sum;
                  if (r_arith) begin
                     r_flag_c <= COut;
                     r_flag_v <= COut ^ CIn_Slice;
                  end
                  r_ctrl      <= '0;
                  r_res_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_DONE: begin
               if (ResReady) begin
                  r_res_valid <= 1'b0;
                  r_op_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
         if (w_load) begin
            r_a        <= OpA;
            r_b        <= OpB;
            r_ctrl     <= w_ctrl;
            r_arith    <= op_sets_carry(alu_op_e'(OpCode));
            r_cnt      <= CNT_INIT;
            r_op_ready <= 1'b0;
            r_state    <= ST_EXEC;
         end
      end
   end

   assign A           = r_a;
   assign B           = r_b;
   assign CIn         = r_ctrl.cin;
   assign SUB         = r_ctrl.sub;
   assign ZeroA       = r_ctrl.zero_a;
   assign FAOut       = r_ctrl.fa_out;
   assign AND         = r_ctrl.and_op;
   assign OR          = r_ctrl.or_op;
   assign XOR         = r_ctrl.xor_op;
   assign NOT         = r_ctrl.not_op;
   assign NAND        = r_ctrl.nand_op;
   assign NOR         = r_ctrl.nor_op;
   assign Sign        = r_ctrl.sign;
   assign ShSignIn    = r_ctrl.sh_sign_in;
   assign Sh1         = r_ctrl.sh1;
   assign Sh2         = r_ctrl.sh2;
   assign Sh4         = r_ctrl.sh4;
   assign Sh8         = r_ctrl.sh8;
   assign ShB         = r_ctrl.sh_b;
   assign ShL         = r_ctrl.sh_l;
   assign ShR         = r_ctrl.sh_r;
   assign ShOut       = r_ctrl.sh_out;
   assign LLI         = r_ctrl.lli;
   assign ALUEnable   = r_ctrl.alu_enable;
   assign ResValid    = r_res_valid;
   assign Result      = r_result;
   assign FlagZ       = r_flag_z;
   assign FlagN       = r_flag_n;
   assign FlagC       = r_flag_c;
   assign FlagV       = r_flag_v;
   assign o_dbg_state = r_state;

endmodule
